// File: rtl/vu_level_proc_if.sv
// vu_level_proc_if: sample input, frame tick and meter outputs of the VU level processor.
// master = sample/frame source side, slave = level processor.
interface vu_level_proc_if #(
    parameter int SEGMENTS = 16
);
    localparam int LW = $clog2(SEGMENTS + 1);

    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          frame_tick;
    logic [LW-1:0] level;
    logic [LW-1:0] peak;
    logic          win_done;
    logic          clip;

    modport master (
        output rx_data,
        output rx_valid,
        output frame_tick,
        input  level,
        input  peak,
        input  win_done,
        input  clip
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  frame_tick,
        output level,
        output peak,
        output win_done,
        output clip
    );
endinterface

// File: rtl/vu_level_proc.sv
// vu_level_proc: windowed peak magnitude of signed 8-bit samples, mapped to a bar
// height with instant attack, per-frame decay and a held peak marker.
// Optional clip indicator is built only when VU_CLIP_EN is defined.
module vu_level_proc #(
    parameter int SEGMENTS   = 16,
    parameter int WINDOW     = 256,
    parameter int HOLD_TICKS = 48,
    parameter int DECAY_STEP = 1
) (
    input  logic          clk,
    input  logic          rst,
    vu_level_proc_if.slave bus
);
    localparam int LW = $clog2(SEGMENTS + 1);
    localparam int CW = $clog2(WINDOW);
    localparam int HW = $clog2(HOLD_TICKS + 1);

    logic [CW-1:0] count_q, count_d;
    logic [6:0]    wmax_q, wmax_d;
    logic [LW-1:0] target_q, target_d;
    logic [LW-1:0] level_q, level_d;
    logic [LW-1:0] peak_q, peak_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          win_done_q, win_done_d;

    logic [7:0]    neg_data;
    logic [6:0]    mag;
    logic [6:0]    wmax_incl;
    logic          win_end;
    logic [LW-1:0] seg;

    assign neg_data = ~bus.rx_data + 8'd1;

    // Sample magnitude (-128 saturates to 127), window max including the current
    // sample, and its mapping onto 0..SEGMENTS.
    always_comb begin
        mag = bus.rx_data[6:0];
        if (bus.rx_data == 8'h80) begin
            mag = 7'h7F;
        end else if (bus.rx_data[7]) begin
            mag = neg_data[6:0];
        end
        wmax_incl = wmax_q;
        if (bus.rx_valid && (mag > wmax_q)) begin
            wmax_incl = mag;
        end
        win_end = bus.rx_valid && (count_q == CW'(WINDOW - 1));
        seg     = LW'(((32'(wmax_incl) + 32'd1) * 32'(SEGMENTS)) >> 7);
    end

    // Window bookkeeping: count samples, track max, publish a new target at window end.
    always_comb begin
        count_d    = count_q;
        wmax_d     = wmax_q;
        target_d   = target_q;
        win_done_d = 1'b0;
        if (bus.rx_valid) begin
            if (win_end) begin
                count_d    = '0;
                wmax_d     = '0;
                target_d   = seg;
                win_done_d = 1'b1;
            end else begin
                count_d = count_q + CW'(1);
                wmax_d  = wmax_incl;
            end
        end
    end

    // Bar height: attack immediately to a higher target; otherwise fall toward the
    // target by DECAY_STEP per frame tick, never undershooting it.
    always_comb begin
        level_d = level_q;
        if (target_d > level_q) begin
            level_d = target_d;
        end else if (bus.frame_tick && (level_q > target_d)) begin
            if ((int'(level_q) - int'(target_d)) > DECAY_STEP) begin
                level_d = level_q - LW'(DECAY_STEP);
            end else begin
                level_d = target_d;
            end
        end
    end

    // Peak marker: jumps up with the bar and re-arms the hold timer; once the hold
    // expires it drops one segment per frame but never below the bar.
    always_comb begin
        peak_d = peak_q;
        hold_d = hold_q;
        if (level_d > peak_q) begin
            peak_d = level_d;
            hold_d = HW'(HOLD_TICKS);
        end else if (bus.frame_tick) begin
            if (hold_q != '0) begin
                hold_d = hold_q - HW'(1);
            end else if (peak_q > level_d) begin
                peak_d = peak_q - LW'(1);
            end
        end
    end

    // Datapath state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q    <= '0;
            wmax_q     <= '0;
            target_q   <= '0;
            level_q    <= '0;
            peak_q     <= '0;
            hold_q     <= '0;
            win_done_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            wmax_q     <= wmax_d;
            target_q   <= target_d;
            level_q    <= level_d;
            peak_q     <= peak_d;
            hold_q     <= hold_d;
            win_done_q <= win_done_d;
        end
    end

    assign bus.level    = level_q;
    assign bus.peak     = peak_q;
    assign bus.win_done = win_done_q;

`ifdef VU_CLIP_EN
    logic [HW-1:0] clip_cnt_q, clip_cnt_d;
    logic          clip_q, clip_d;

    // Clip timer: any full-scale sample reloads it, frame ticks run it down.
    always_comb begin
        clip_cnt_d = clip_cnt_q;
        if (bus.rx_valid && (mag == 7'h7F)) begin
            clip_cnt_d = HW'(HOLD_TICKS);
        end else if (bus.frame_tick && (clip_cnt_q != '0)) begin
            clip_cnt_d = clip_cnt_q - HW'(1);
        end
        clip_d = (clip_cnt_d != '0);
    end

    // Clip timer and registered indicator.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clip_cnt_q <= '0;
            clip_q     <= 1'b0;
        end else begin
            clip_cnt_q <= clip_cnt_d;
            clip_q     <= clip_d;
        end
    end

    assign bus.clip = clip_q;
`else
    assign bus.clip = 1'b0;
`endif

endmodule

// File: tb/tb_vu_level_proc.sv
// Directed bench for vu_level_proc: window mapping, attack/decay, peak hold,
// asynchronous reset and (when VU_CLIP_EN is defined) the clip indicator.
module tb_vu_level_proc;
`ifdef VU_CLIP_EN
    localparam int CLIP_ON = 1;
`else
    localparam int CLIP_ON = 0;
`endif

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   wd_cnt;

    vu_level_proc_if #(.SEGMENTS(16)) bus ();

    vu_level_proc #(
        .SEGMENTS(16),
        .WINDOW(256),
        .HOLD_TICKS(48),
        .DECAY_STEP(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count win_done cycles shortly after each rising edge.
    always @(posedge clk) begin
        #1;
        if (bus.win_done === 1'b1) wd_cnt++;
    end

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic tick);
        @(negedge clk);
        bus.rx_data    = d;
        bus.rx_valid   = 1'b1;
        bus.frame_tick = tick;
        @(negedge clk);
        bus.rx_valid   = 1'b0;
        bus.frame_tick = 1'b0;
    endtask

    task automatic send_n(input int n, input logic [7:0] d);
        for (int i = 0; i < n; i++) send(d, 1'b0);
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.frame_tick = 1'b1;
            @(negedge clk);
            bus.frame_tick = 1'b0;
        end
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        wd_cnt         = 0;
        rst            = 1'b1;
        bus.rx_data    = 8'h00;
        bus.rx_valid   = 1'b0;
        bus.frame_tick = 1'b0;
        #22;
        check_val("rst_level", int'(bus.level), 0);
        check_val("rst_peak", int'(bus.peak), 0);
        check_val("rst_win_done", int'(bus.win_done), 0);
        check_val("rst_clip", int'(bus.clip), 0);
        @(negedge clk);
        rst = 1'b0;
        wd_cnt = 0;

        // Window of 0x40 -> 8 segments on the final sample's edge.
        send_n(255, 8'h40);
        check_val("w40_no_done_early", wd_cnt, 0);
        check_val("w40_level_before", int'(bus.level), 0);
        send(8'h40, 1'b0);
        check_val("w40_win_done", int'(bus.win_done), 1);
        check_val("w40_level", int'(bus.level), 8);
        check_val("w40_peak", int'(bus.peak), 8);
        repeat (5) @(negedge clk);
        check_val("w40_level_hold", int'(bus.level), 8);
        check_val("w40_done_once", wd_cnt, 1);
        check_val("w40_done_low", int'(bus.win_done), 0);

        // Silent window, then decay and peak hold.
        send_n(256, 8'h00);
        check_val("w00_done", wd_cnt, 2);
        check_val("w00_level_no_tick", int'(bus.level), 8);
        tick_n(1);
        check_val("dec_t1", int'(bus.level), 7);
        tick_n(1);
        check_val("dec_t2", int'(bus.level), 6);
        tick_n(1);
        check_val("dec_t3", int'(bus.level), 5);
        check_val("dec_t3_peak", int'(bus.peak), 8);
        tick_n(45);
        check_val("t48_peak", int'(bus.peak), 8);
        check_val("t48_level", int'(bus.level), 0);
        tick_n(1);
        check_val("t49_peak", int'(bus.peak), 7);
        check_val("t49_level", int'(bus.level), 0);
        tick_n(11);
        check_val("t60_peak", int'(bus.peak), 0);
        check_val("t60_level", int'(bus.level), 0);

        // level=4, then a window of magnitude 96 completing with a frame tick.
        send_n(256, 8'h1F);
        check_val("w1f_level", int'(bus.level), 4);
        check_val("w1f_peak", int'(bus.peak), 4);
        send_n(255, 8'h60);
        check_val("w60_level_before", int'(bus.level), 4);
        send(8'hA0, 1'b1);
        check_val("w60_tick_done", int'(bus.win_done), 1);
        check_val("w60_tick_level", int'(bus.level), 12);
        check_val("w60_tick_peak", int'(bus.peak), 12);

        // Silent window ending in -128: the completing sample counts, full scale.
        send_n(255, 8'h00);
        check_val("w80_level_before", int'(bus.level), 12);
        check_val("w80_clip_before", int'(bus.clip), 0);
        send(8'h80, 1'b0);
        check_val("w80_level", int'(bus.level), 16);
        check_val("w80_peak", int'(bus.peak), 16);
        check_val("w80_clip", int'(bus.clip), CLIP_ON);
        tick_n(47);
        check_val("clip_t47", int'(bus.clip), CLIP_ON);
        check_val("clip_t47_level", int'(bus.level), 16);
        tick_n(1);
        check_val("clip_t48", int'(bus.clip), 0);
        check_val("clip_t48_peak", int'(bus.peak), 16);

        // Partial window, asynchronous reset, then a full fresh window.
        send_n(100, 8'h7F);
        check_val("part_clip", int'(bus.clip), CLIP_ON);
        check_val("part_level", int'(bus.level), 16);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_val("arst_level", int'(bus.level), 0);
        check_val("arst_peak", int'(bus.peak), 0);
        check_val("arst_win_done", int'(bus.win_done), 0);
        check_val("arst_clip", int'(bus.clip), 0);
        @(negedge clk);
        rst = 1'b0;
        wd_cnt = 0;
        send_n(255, 8'h10);
        check_val("post_rst_no_done", wd_cnt, 0);
        check_val("post_rst_level0", int'(bus.level), 0);
        send(8'h10, 1'b0);
        check_val("post_rst_done", int'(bus.win_done), 1);
        check_val("post_rst_level", int'(bus.level), 2);
        check_val("post_rst_peak", int'(bus.peak), 2);
        @(negedge clk);
        check_val("post_rst_done_cnt", wd_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
